// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: upstream sequencer producing the sel/enable pair for a
// one-hot decoder. Steps sel through the channels, holding each one with
// enable=1 for DWELL cycles, with an optional BLANK-cycle enable=0 gap between
// channels for break-before-make. Supports single-pass and continuous scans.
// Optional feature macro: SCAN_SKIP_MASK_EN adds a skip_mask input; masked
// channels are never driven and the scan jumps to the next unmasked index.
// All outputs are registered.
module decoder_scan_ctrl #(
   parameter int WIDTH = 16,
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     continuous,
`ifdef SCAN_SKIP_MASK_EN
   input  logic [WIDTH-1:0]         skip_mask,
`endif
   output logic [$clog2(WIDTH)-1:0] sel,
   output logic                     enable,
   output logic                     busy,
   output logic                     done,
   output logic                     wrap
);

   localparam int SW   = $clog2(WIDTH);
   localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   // Unused when BLANK=0 (GAP is unreachable then).
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;

   state_t          state, nstate;
   logic [CW-1:0]   cnt, ncnt;
   logic            cont_q, ncont;
   // Index (and wrap flag) of the next channel, decided when a dwell ends
   // and held through the gap so the mask is only sampled at the decision.
   logic [SW-1:0]   tgt, ntgt;
   logic            tgt_wrap, ntgt_wrap;

   logic [SW-1:0]   nsel;
   logic            nen, nbusy, ndone, nwrap;

   logic [WIDTH-1:0] mask;
   logic             has_any, has_up;
   logic [SW-1:0]    low_idx, up_idx;

`ifdef SCAN_SKIP_MASK_EN
   assign mask = skip_mask;
`else
   assign mask = '0;
`endif

   // Find the lowest unmasked channel and the first unmasked one above sel.
   always_comb begin
      has_any = 1'b0;
      has_up  = 1'b0;
      low_idx = '0;
      up_idx  = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!mask[i]) begin
            has_any = 1'b1;
            low_idx = SW'(i);
            if (i > int'(sel)) begin
               has_up = 1'b1;
               up_idx = SW'(i);
            end
         end
      end
   end

   // State register plus registered outputs; reset dominates everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         cont_q   <= 1'b0;
         tgt      <= '0;
         tgt_wrap <= 1'b0;
         sel      <= '0;
         enable   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         state    <= nstate;
         cnt      <= ncnt;
         cont_q   <= ncont;
         tgt      <= ntgt;
         tgt_wrap <= ntgt_wrap;
         sel      <= nsel;
         enable   <= nen;
         busy     <= nbusy;
         done     <= ndone;
         wrap     <= nwrap;
      end
   end

   // Next-state logic: dwell/gap counting and the advance decision.
   always_comb begin
      nstate    = state;
      ncnt      = cnt;
      ncont     = cont_q;
      ntgt      = tgt;
      ntgt_wrap = tgt_wrap;
      case (state)
         IDLE: begin
            ncnt = '0;
            if (start && !stop) begin
               ncont = continuous;
               if (has_any) begin
                  nstate    = DRIVE;
                  ntgt      = low_idx;
                  ntgt_wrap = 1'b0;
               end else if (!continuous) begin
                  nstate = DONE;
               end
            end
         end
         DRIVE: begin
            if (stop) begin
               nstate = IDLE;
               ncnt   = '0;
            end else if (cnt == DWELL_LAST) begin
               ncnt = '0;
               if (has_up) begin
                  ntgt      = up_idx;
                  ntgt_wrap = 1'b0;
                  nstate    = (BLANK > 0) ? GAP : DRIVE;
               end else if (cont_q && has_any) begin
                  ntgt      = low_idx;
                  ntgt_wrap = 1'b1;
                  nstate    = (BLANK > 0) ? GAP : DRIVE;
               end else if (cont_q) begin
                  // every channel masked mid-scan: nothing left to drive
                  nstate = IDLE;
               end else begin
                  nstate = DONE;
               end
            end else begin
               ncnt = cnt + CW'(1);
            end
         end
         GAP: begin
            if (stop) begin
               nstate = IDLE;
               ncnt   = '0;
            end else if (cnt == BLANK_LAST) begin
               nstate = DRIVE;
               ncnt   = '0;
            end else begin
               ncnt = cnt + CW'(1);
            end
         end
         default: begin
            nstate = IDLE;
            ncnt   = '0;
         end
      endcase
   end

   // Output logic: values the output registers take for the next state.
   always_comb begin
      nsel  = sel;
      nen   = 1'b0;
      nbusy = 1'b0;
      ndone = 1'b0;
      nwrap = 1'b0;
      case (nstate)
         IDLE: nsel = '0;
         DRIVE: begin
            nen   = 1'b1;
            nbusy = 1'b1;
            // sel only moves on entry to a new dwell, never while enabled
            if (state != DRIVE || cnt == DWELL_LAST) begin
               nsel  = ntgt;
               nwrap = ntgt_wrap;
            end
         end
         GAP:     nbusy = 1'b1;
         default: ndone = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: a per-cycle vector table for control corner
// cases, then directed single/continuous/stop/reset scans with expected
// values computed from the scan arithmetic. Second instance covers BLANK=0
// with a non-power-of-2 WIDTH.
module tb_decoder_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1, start = 1'b0, stop = 1'b0, continuous = 1'b0;
   logic [3:0] sel;
   logic       enable, busy, done, wrap;

   logic       start2 = 1'b0, stop2 = 1'b0, cont2 = 1'b0;
   logic [2:0] sel2;
   logic       enable2, busy2, done2, wrap2;

`ifdef SCAN_SKIP_MASK_EN
   logic [15:0] skip_mask  = '0;
   logic [4:0]  skip_mask2 = '0;
`endif

   always #5 clk = ~clk;

   decoder_scan_ctrl #(.WIDTH(16), .DWELL(4), .BLANK(1)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .continuous(continuous),
`ifdef SCAN_SKIP_MASK_EN
      .skip_mask(skip_mask),
`endif
      .sel(sel), .enable(enable), .busy(busy), .done(done), .wrap(wrap)
   );

   decoder_scan_ctrl #(.WIDTH(5), .DWELL(2), .BLANK(0)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .stop(stop2),
      .continuous(cont2),
`ifdef SCAN_SKIP_MASK_EN
      .skip_mask(skip_mask2),
`endif
      .sel(sel2), .enable(enable2), .busy(busy2), .done(done2), .wrap(wrap2)
   );

   int n_pass = 0, n_chk = 0;

   typedef struct {
      logic       rst, st, sp, ct;
      logic [3:0] s;
      logic       e, b, d, w;
   } vec_t;
   vec_t tbl[23];

   function automatic logic [15:0] pk(input logic [7:0] s, input logic e, b, d, w);
      return {4'b0, s, e, b, d, w};
   endfunction

   function automatic vec_t v(input logic rst, st, sp, ct, input logic [3:0] s,
                              input logic e, b, d, w);
      vec_t r;
      r.rst = rst; r.st = st; r.sp = sp; r.ct = ct;
      r.s = s; r.e = e; r.b = b; r.d = d; r.w = w;
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] cur1();
      return pk(8'(sel), enable, busy, done, wrap);
   endfunction

   function automatic logic [15:0] cur2();
      return pk(8'(sel2), enable2, busy2, done2, wrap2);
   endfunction

   // Single pass, 16 channels, 4 on + 1 gap; last channel goes straight to DONE.
   function automatic logic [15:0] exp_single(input int n);
      if (n < 79)       return pk(8'(n / 5), (n % 5) < 4, 1'b1, 1'b0, 1'b0);
      else if (n == 79) return pk(8'd15, 1'b0, 1'b0, 1'b1, 1'b0);
      else              return pk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   int dcnt, wcnt;
   logic [15:0] z;

   initial begin
      z = pk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      //            rst st sp ct  sel e  b  d  w
      tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0);  // reset values
      tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = v(0, 1, 1, 0, 0, 0, 0, 0, 0);  // start+stop: stop wins
      tbl[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = v(0, 1, 0, 0, 0, 1, 1, 0, 0);  // latency 1 to sel0 enable
      tbl[5]  = v(0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[6]  = v(0, 1, 0, 0, 0, 1, 1, 0, 0);  // start while busy ignored
      tbl[7]  = v(0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[8]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0);  // gap, sel held
      tbl[9]  = v(0, 0, 0, 0, 1, 1, 1, 0, 0);
      tbl[10] = v(0, 0, 1, 0, 0, 0, 0, 0, 0);  // stop in DRIVE
      tbl[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[12] = v(0, 1, 0, 0, 0, 1, 1, 0, 0);
      tbl[13] = v(1, 0, 0, 0, 0, 0, 0, 0, 0);  // reset mid-scan
      tbl[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = v(0, 1, 0, 0, 0, 1, 1, 0, 0);
      tbl[16] = v(0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[17] = v(0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[18] = v(0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[19] = v(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[20] = v(0, 0, 1, 0, 0, 0, 0, 0, 0);  // stop in GAP
      tbl[21] = v(1, 1, 0, 0, 0, 0, 0, 0, 0);  // reset beats start
      tbl[22] = v(0, 0, 0, 0, 0, 0, 0, 0, 0);

      #1;
      for (int i = 0; i < 23; i++) begin
         reset = tbl[i].rst; start = tbl[i].st; stop = tbl[i].sp; continuous = tbl[i].ct;
         step();
         check($sformatf("vec%0d", i), cur1(),
               pk(8'(tbl[i].s), tbl[i].e, tbl[i].b, tbl[i].d, tbl[i].w));
      end
      start = 0; stop = 0; continuous = 0;
      check("dut2_reset", cur2(), z);

      // Single pass; continuous toggles and a busy start are ignored.
      dcnt = 0;
      start = 1;
      for (int n = 0; n <= 81; n++) begin
         step();
         start = (n == 50);
         if (n == 30) continuous = 1;
         if (n == 40) continuous = 0;
         if (done) dcnt++;
         check($sformatf("single n=%0d", n), cur1(), exp_single(n));
      end
      check("single_done_count", 16'(dcnt), 16'd1);

      // Continuous, two passes and some; clearing continuous mid-scan ignored.
      wcnt = 0;
      continuous = 1; start = 1;
      for (int n = 0; n < 170; n++) begin
         step();
         start = 0;
         if (n == 100) continuous = 0;
         if (wrap) wcnt++;
         check($sformatf("cont n=%0d", n), cur1(),
               pk(8'((n % 80) / 5), (n % 5) < 4, 1'b1, 1'b0, (n % 80 == 0) && (n > 0)));
      end
      check("cont_wrap_count", 16'(wcnt), 16'd2);
      stop = 1; step(); stop = 0;
      check("cont_stop", cur1(), z);

      // Stop at sel=5 mid-dwell, then restart and reset at sel=9.
      start = 1;
      for (int n = 0; n <= 26; n++) begin
         step();
         start = 0;
         check($sformatf("pre_stop n=%0d", n), cur1(), exp_single(n));
      end
      stop = 1; step(); stop = 0;
      check("stop_sel5", cur1(), z);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("after_stop %0d", k), cur1(), z);
      end
      start = 1;
      for (int n = 0; n <= 46; n++) begin
         step();
         start = 0;
         check($sformatf("restart n=%0d", n), cur1(), exp_single(n));
      end
      reset = 1; start = 1; step(); reset = 0; start = 0;
      check("reset_sel9", cur1(), z);
      step();
      check("after_reset", cur1(), z);

      // BLANK=0, WIDTH=5: back-to-back drives, enable never drops.
      start2 = 1;
      for (int n = 0; n <= 11; n++) begin
         step();
         start2 = 0;
         if (n < 10)       check($sformatf("b0 n=%0d", n), cur2(), pk(8'(n / 2), 1'b1, 1'b1, 1'b0, 1'b0));
         else if (n == 10) check("b0_done", cur2(), pk(8'd4, 1'b0, 1'b0, 1'b1, 1'b0));
         else              check("b0_idle", cur2(), z);
      end
      cont2 = 1; start2 = 1;
      for (int n = 0; n < 25; n++) begin
         step();
         start2 = 0;
         check($sformatf("b0c n=%0d", n), cur2(),
               pk(8'((n % 10) / 2), 1'b1, 1'b1, 1'b0, (n % 10 == 0) && (n > 0)));
      end
      stop2 = 1; step(); stop2 = 0; cont2 = 0;
      check("b0c_stop", cur2(), z);

`ifdef SCAN_SKIP_MASK_EN
      begin
         logic [7:0] lst[12];
         for (int i = 0; i < 4; i++)  lst[i] = 8'(i);
         for (int i = 4; i < 12; i++) lst[i] = 8'(i + 4);
         skip_mask = 16'h00F0;
         start = 1;
         for (int n = 0; n <= 60; n++) begin
            step();
            start = 0;
            if (n < 59)       check($sformatf("mask n=%0d", n), cur1(), pk(lst[n / 5], (n % 5) < 4, 1'b1, 1'b0, 1'b0));
            else if (n == 59) check("mask_done", cur1(), pk(8'd15, 1'b0, 1'b0, 1'b1, 1'b0));
            else              check("mask_idle", cur1(), z);
         end
         skip_mask = 16'hFFFF;
         start = 1; step(); start = 0;
         check("allmask_done", cur1(), pk(8'd0, 1'b0, 1'b0, 1'b1, 1'b0));
         step();
         check("allmask_idle", cur1(), z);
         continuous = 1; start = 1; step(); start = 0; continuous = 0;
         check("allmask_cont", cur1(), z);
         step();
         check("allmask_cont2", cur1(), z);
         skip_mask = '0;
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
